// File: rtl/iter_down_counter.sv
// -----------------------------------------------------------------------------
// iter_down_counter
//
// Loadable down-counter with a start/done handshake. It sequences iterative
// datapaths (divider, square root): a job loads an iteration count, the block
// strobes one step per enabled cycle, and it flags completion until the
// consumer acknowledges it.
//
// Parameters
//   SIZE      width of load_val, count and idx (default 8)
//
// Ports
//   clk       in   1     rising-edge clock
//   rst       in   1     asynchronous, active-high reset
//   sync_rst  in   1     synchronous abort back to IDLE (beats start)
//   start     in   1     job request; taken in IDLE, or in DONE together with ack
//   load_val  in   SIZE  iteration count N, sampled when start is taken
//   en        in   1     step enable; 0 stalls RUN with count held
//   ack       in   1     consumer acknowledge of done
//   count     out  SIZE  remaining iterations (registered)
//   busy      out  1     block is in RUN (registered)
//   step      out  1     busy & en, one datapath iteration this cycle
//   last      out  1     busy & count==1, final iteration pending
//   done      out  1     job finished, held until ack (registered)
//   idx       out  SIZE  iterations completed (only with ITER_CNT_IDX_EN)
//
// Configuration
//   ITER_CNT_IDX_EN  when defined, adds the registered idx output. When not
//                    defined, idx and its register are absent and all other
//                    behaviour is unchanged.
// -----------------------------------------------------------------------------
module iter_down_counter #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sync_rst,
  input  logic            start,
  input  logic [SIZE-1:0] load_val,
  input  logic            en,
  input  logic            ack,
  output logic [SIZE-1:0] count,
  output logic            busy,
  output logic            step,
  output logic            last,
  output logic            done
`ifdef ITER_CNT_IDX_EN
  ,
  output logic [SIZE-1:0] idx
`endif
);

  localparam logic [SIZE-1:0] ZERO = {SIZE{1'b0}};
  localparam logic [SIZE-1:0] ONE  = {{(SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [SIZE-1:0] count_r;
  logic            busy_r;
  logic            done_r;
  logic            accept_s;
  logic            load_zero_s;

  // Start acceptance and zero-iteration detection for the load path.
  always_comb begin
    accept_s    = start & ((state_r == IDLE) | ((state_r == DONE) & ack));
    load_zero_s = (load_val == ZERO);
  end

  // Control FSM with registered count/busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (sync_rst) begin
      // Abort wins over any start presented in the same cycle.
      state_r <= IDLE;
      count_r <= ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            // A zero-iteration job skips RUN and completes immediately.
            state_r <= load_zero_s ? DONE : RUN;
            count_r <= load_val;
            busy_r  <= !load_zero_s;
            done_r  <= load_zero_s;
          end else if ((state_r == DONE) && ack) begin
            state_r <= IDLE;
            count_r <= ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            state_r <= state_r;
            count_r <= ZERO;
            busy_r  <= 1'b0;
            done_r  <= (state_r == DONE);
          end
        end
        RUN: begin
          if (en) begin
            // <= rather than == so a corrupted zero count can never wrap.
            if (count_r <= ONE) begin
              state_r <= DONE;
              count_r <= ZERO;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
              count_r <= count_r - ONE;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            state_r <= RUN;
            count_r <= count_r;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= ZERO;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign step  = busy_r & en;
  assign last  = busy_r & (count_r == ONE);

`ifdef ITER_CNT_IDX_EN
  logic [SIZE-1:0] idx_r;

  // Completed-iteration index: cleared on job start, bumped on every step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= ZERO;
    end else if (sync_rst) begin
      idx_r <= ZERO;
    end else if (accept_s) begin
      idx_r <= ZERO;
    end else if (step) begin
      idx_r <= idx_r + ONE;
    end else begin
      idx_r <= idx_r;
    end
  end

  assign idx = idx_r;
`endif

endmodule

// File: tb/tb_iter_down_counter.sv
// -----------------------------------------------------------------------------
// tb_iter_down_counter
//
// Directed self-checking bench for iter_down_counter (SIZE=8). Inputs change
// 1 ns after each rising edge; outputs are checked 1 ns later, well away from
// the next edge.
// -----------------------------------------------------------------------------
module tb_iter_down_counter;

  localparam int SIZE = 8;

  logic            clk;
  logic            rst;
  logic            sync_rst;
  logic            start;
  logic [SIZE-1:0] load_val;
  logic            en;
  logic            ack;
  logic [SIZE-1:0] count;
  logic            busy;
  logic            step;
  logic            last;
  logic            done;
`ifdef ITER_CNT_IDX_EN
  logic [SIZE-1:0] idx;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_steps  = 0;

  iter_down_counter #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .sync_rst (sync_rst),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .ack      (ack),
    .count    (count),
    .busy     (busy),
    .step     (step),
    .last     (last),
    .done     (done)
`ifdef ITER_CNT_IDX_EN
    ,
    .idx      (idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [SIZE-1:0] c,
                           input logic b, input logic d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    logic [4:0] en_seq;
    logic [7:0] exp3 [0:4];

    rst = 1'b1; sync_rst = 1'b0; start = 1'b0; load_val = 8'd0; en = 1'b0; ack = 1'b0;
    #3;
    // Reset state
    chk_state("reset", 8'd0, 1'b0, 1'b0);
    chk("reset.step", 32'(step), 32'd0);
    chk("reset.last", 32'(last), 32'd0);
`ifdef ITER_CNT_IDX_EN
    chk("reset.idx", 32'(idx), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // N=4, en held high
    start = 1'b1; load_val = 8'd4; en = 1'b1;
    tick();
    start = 1'b0; load_val = 8'd0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        // start and ack during RUN must be ignored
        start = 1'b1; ack = 1'b1; load_val = 8'd9;
      end else begin
        start = 1'b0; ack = 1'b0; load_val = 8'd0;
      end
      settle();
      chk_state($sformatf("n4.c%0d", i), 8'(5 - i), 1'b1, 1'b0);
      chk($sformatf("n4.c%0d.step", i), 32'(step), 32'd1);
      chk($sformatf("n4.c%0d.last", i), 32'(last), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    start = 1'b0; ack = 1'b0; load_val = 8'd0;
    settle();
    chk_state("n4.done", 8'd0, 1'b0, 1'b1);
    chk("n4.done.step", 32'(step), 32'd0);
`ifdef ITER_CNT_IDX_EN
    chk("n4.idx", 32'(idx), 32'd4);
`endif
    // done held without ack
    tick();
    chk("n4.hold", 32'(done), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    settle();
    chk_state("n4.ack", 8'd0, 1'b0, 1'b0);

    // N=3 with en pattern 1,0,0,1,1
    en_seq = 5'b11001;                 // bit i = en in run cycle i
    exp3[0] = 8'd3; exp3[1] = 8'd2; exp3[2] = 8'd2; exp3[3] = 8'd2; exp3[4] = 8'd1;
    start = 1'b1; load_val = 8'd3; en = 1'b1;
    tick();
    start = 1'b0; load_val = 8'd0;
    n_steps = 0;
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i];
      settle();
      chk_state($sformatf("stall.c%0d", i), exp3[i], 1'b1, 1'b0);
      chk($sformatf("stall.c%0d.step", i), 32'(step), 32'(en_seq[i]));
      if (step === 1'b1) n_steps++;
      tick();
    end
    en = 1'b1;
    settle();
    chk_state("stall.done", 8'd0, 1'b0, 1'b1);
    chk("stall.steps", 32'(n_steps), 32'd3);
`ifdef ITER_CNT_IDX_EN
    chk("stall.idx", 32'(idx), 32'd3);
`endif
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // N=0: straight to DONE
    start = 1'b1; load_val = 8'd0;
    tick();
    start = 1'b0;
    settle();
    chk_state("zero", 8'd0, 1'b0, 1'b1);
    chk("zero.step", 32'(step), 32'd0);
`ifdef ITER_CNT_IDX_EN
    chk("zero.idx", 32'(idx), 32'd0);
`endif

    // Back-to-back: ack + start from DONE, N=2
    ack = 1'b1; start = 1'b1; load_val = 8'd2;
    tick();
    ack = 1'b0; start = 1'b0; load_val = 8'd0;
    settle();
    chk_state("b2b", 8'd2, 1'b1, 1'b0);
    tick();
    tick();
    chk_state("b2b.done", 8'd0, 1'b0, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // sync_rst with start at count=7
    start = 1'b1; load_val = 8'd9;
    tick();
    start = 1'b0; load_val = 8'd0;
    tick();
    tick();
    chk_state("srst.pre", 8'd7, 1'b1, 1'b0);
    sync_rst = 1'b1; start = 1'b1; load_val = 8'd5;
    tick();
    sync_rst = 1'b0; start = 1'b0; load_val = 8'd0;
    settle();
    chk_state("srst", 8'd0, 1'b0, 1'b0);
    chk("srst.step", 32'(step), 32'd0);
`ifdef ITER_CNT_IDX_EN
    chk("srst.idx", 32'(idx), 32'd0);
`endif
    tick();
    chk_state("srst.after", 8'd0, 1'b0, 1'b0);

    // Max count 255
    start = 1'b1; load_val = 8'd255;
    tick();
    start = 1'b0; load_val = 8'd0;
    chk_state("max", 8'd255, 1'b1, 1'b0);
    tick();
    chk_state("max.dec", 8'd254, 1'b1, 1'b0);
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;

    // Async rst mid-RUN at count=5
    start = 1'b1; load_val = 8'd5;
    tick();
    start = 1'b0; load_val = 8'd0;
    chk_state("arst.pre", 8'd5, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_state("arst", 8'd0, 1'b0, 1'b0);
    chk("arst.step", 32'(step), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk_state("arst.after", 8'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
